freq_ctl_sweep: RTL and testbench

FREQ_CTL_SWEEP -- requirements
Module: freq_ctl_sweep

---
 rtl/freq_pkg.sv | 15 +
 rtl/ftw_conv.sv | 55 +++++
 rtl/freq_ctl_sweep.sv | 135 +++++++++++++
 tb/tb_freq_ctl_sweep.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared constants and FSM encoding for the frequency control / sweep block.
package freq_pkg;

  localparam int unsigned CLK_FREQ_HZ  = 100_000_000;
  localparam int unsigned SCALE_Q_DFLT = 10995116;
  localparam int unsigned FRAC_W_DFLT  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIXED = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ftw_conv.sv
// Two-stage code-to-FTW converter: full-width multiply, then round-half-up and shift.
module ftw_conv
  import freq_pkg::*;
#(
  parameter int          CTL_W   = 12,
  parameter int          FTW_W   = 32,
  parameter int unsigned SCALE_Q = SCALE_Q_DFLT,
  parameter int          FRAC_W  = FRAC_W_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CTL_W-1:0] i_code,
  input  logic             i_vld,
  output logic [FTW_W-1:0] o_ftw,
  output logic             o_vld
);

  localparam int SQ_W   = $clog2(SCALE_Q + 1);
  localparam int PROD_W = CTL_W + SQ_W;
  localparam int SUM_W  = PROD_W + FTW_W + 1;
  localparam logic [SUM_W-1:0] RND = (FRAC_W > 0) ? (SUM_W'(1) << (FRAC_W - 1)) : '0;

  logic [PROD_W-1:0] r_prod_p1;
  logic              r_vld_p1;
  logic [FTW_W-1:0]  r_ftw_p2;
  logic              r_vld_p2;

  function automatic logic [FTW_W-1:0] round_shift(input logic [PROD_W-1:0] p);
    logic [SUM_W-1:0] s;
    s = SUM_W'(p) + RND;
    return FTW_W'(s >> FRAC_W);
  endfunction

  // stage 1: multiply
  always_ff @(posedge clk) begin
    if (i_vld) r_prod_p1 <= PROD_W'(i_code) * PROD_W'(SCALE_Q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_ftw_p2 <= '0;
    end else begin
      r_vld_p1 <= i_vld;
      // stage 2: round and shift; the output holds between updates
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) r_ftw_p2 <= round_shift(r_prod_p1);
    end
  end

  assign o_ftw = r_ftw_p2;
  assign o_vld = r_vld_p2;

endmodule

// File: rtl/freq_ctl_sweep.sv
// Fixed-frequency / linear-sweep tuning word generator with a dwell-timed code stepper.
module freq_ctl_sweep
  import freq_pkg::*;
#(
  parameter int          CTL_W   = 12,
  parameter int          FTW_W   = 32,
  parameter int unsigned SCALE_Q = SCALE_Q_DFLT,
  parameter int          FRAC_W  = FRAC_W_DFLT,
  parameter int          DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [CTL_W-1:0]   freq_ctl,
  input  logic [CTL_W-1:0]   stop_ctl,
  input  logic [CTL_W-1:0]   step_ctl,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FTW_W-1:0]   freq_ctl_data,
  output logic               ftw_valid,
  output logic               sweep_busy,
  output logic               sweep_done
);

  logic               r_rst_meta;
  logic               r_rst_sync;
  state_t             r_state;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_ready;
  logic [CTL_W-1:0]   r_cur;
  logic [CTL_W-1:0]   r_stop;
  logic [CTL_W-1:0]   r_step;
  logic [DWELL_W-1:0] r_dwell;

  logic               w_rst_n;
  logic               w_accept;
  logic [CTL_W:0]     w_sum;
  logic               w_end;
  logic               w_tick;
  logic               w_inj_vld;
  logic [CTL_W-1:0]   w_inj_code;

  // reset asserts immediately, releases two clocks after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n    = r_rst_sync;
  assign w_accept   = load_valid && r_ready;
  assign w_sum      = {1'b0, r_cur} + {1'b0, r_step};
  assign w_end      = w_sum[CTL_W] || (w_sum[CTL_W-1:0] > r_stop);
  assign w_tick     = (r_state == ST_SWEEP) && (r_cnt == r_dwell);
  assign w_inj_vld  = w_accept || (w_tick && !w_end);
  assign w_inj_code = w_accept ? freq_ctl : w_sum[CTL_W-1:0];

  always_ff @(posedge clk) begin
    if (w_accept && mode) begin
      r_cur   <= freq_ctl;
      r_stop  <= stop_ctl;
      r_step  <= step_ctl;
      r_dwell <= dwell;
    end else if (w_tick && !w_end) begin
      r_cur <= w_sum[CTL_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_cnt <= '0;
        if (mode) begin
          r_state <= ST_SWEEP;
          r_busy  <= 1'b1;
          r_ready <= 1'b0;
        end else begin
          r_state <= ST_FIXED;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_SWEEP: begin
            if (w_tick) begin
              r_cnt <= '0;
              if (w_end) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          // ready is withheld during the sweep_done cycle itself
          default: r_ready <= 1'b1;
        endcase
      end
    end
  end

  ftw_conv #(
    .CTL_W  (CTL_W),
    .FTW_W  (FTW_W),
    .SCALE_Q(SCALE_Q),
    .FRAC_W (FRAC_W)
  ) u_conv (
    .clk   (clk),
    .rst_n (w_rst_n),
    .i_code(w_inj_code),
    .i_vld (w_inj_vld),
    .o_ftw (freq_ctl_data),
    .o_vld (ftw_valid)
  );

  assign load_ready = r_ready;
  assign sweep_busy = r_busy;
  assign sweep_done = r_done;

endmodule

// File: tb/tb_freq_ctl_sweep.sv
// Scoreboard bench: stimulus pushes expected (cycle, FTW) and done events; a negedge monitor pops them.
module tb_freq_ctl_sweep;

  localparam longint unsigned SCALE = 64'd10995116;
  localparam int FRAC = 8;
  localparam int MAXC = 4095;
  localparam int NEVER = 32'h7fffffff;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [11:0] freq_ctl = '0;
  logic [11:0] stop_ctl = '0;
  logic [11:0] step_ctl = '0;
  logic [15:0] dwell = '0;
  logic [31:0] freq_ctl_data;
  logic        ftw_valid;
  logic        sweep_busy;
  logic        sweep_done;

  freq_ctl_sweep dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .freq_ctl     (freq_ctl),
    .stop_ctl     (stop_ctl),
    .step_ctl     (step_ctl),
    .dwell        (dwell),
    .freq_ctl_data(freq_ctl_data),
    .ftw_valid    (ftw_valid),
    .sweep_busy   (sweep_busy),
    .sweep_done   (sweep_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t        q[$];
  int          dq[$];
  exp_t        e;
  int          d;
  int          n_chk = 0;
  int          n_fail = 0;
  int          sw_t0 = -10;
  int          sw_done = -5;
  logic [31:0] last_val = '0;
  bit          mon_en = 1'b0;

  function automatic logic [31:0] ftw_of(input int code);
    longint unsigned p;
    p = SCALE * longint'(code) + (64'd1 << (FRAC - 1));
    return 32'(p >> FRAC);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (ftw_valid) begin
        if (q.size() == 0) chk("ftw_valid with nothing due", ftw_valid, 0);
        else begin
          e = q.pop_front();
          chk("ftw_valid cycle", cyc, e.cyc);
          chk("freq_ctl_data value", freq_ctl_data, e.val);
        end
      end
      if (sweep_done) begin
        if (dq.size() == 0) chk("sweep_done with nothing due", sweep_done, 0);
        else begin
          d = dq.pop_front();
          chk("sweep_done cycle", cyc, d);
        end
      end
      chk("load_ready", load_ready, !(cyc > sw_t0 && cyc <= sw_done));
      chk("sweep_busy", sweep_busy, (cyc > sw_t0 && cyc < sw_done));
    end
  end

  task automatic do_fixed(input int f);
    mode = 1'b0;
    freq_ctl = 12'(f);
    load_valid = 1'b1;
    last_val = ftw_of(f);
    q.push_back('{cyc: cyc + 2, val: last_val});
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Model: code k appears at t0+2+k*(dwell+1); done one dwell period after the last code's slot.
  task automatic do_sweep(input int s, input int stp, input int st, input int dw,
                          input bit hold, input int nlimit);
    int c, k, t0;
    bit ends;
    c = s; k = 0; t0 = cyc; ends = 1'b0;
    mode = 1'b1;
    freq_ctl = 12'(s);
    stop_ctl = 12'(stp);
    step_ctl = 12'(st);
    dwell = 16'(dw);
    load_valid = 1'b1;
    while (k < nlimit) begin
      last_val = ftw_of(c);
      q.push_back('{cyc: t0 + 2 + k * (dw + 1), val: last_val});
      k++;
      if (c + st > stp || c + st > MAXC) begin
        ends = 1'b1;
        break;
      end
      c = c + st;
    end
    sw_t0 = t0;
    sw_done = ends ? t0 + 1 + k * (dw + 1) : NEVER;
    if (ends) dq.push_back(sw_done);
    @(negedge clk);
    while (hold && cyc < sw_done && cyc < t0 + 5000) begin
      mode = 1'($urandom_range(0, 1));
      freq_ctl = 12'($urandom);
      stop_ctl = 12'($urandom);
      step_ctl = 12'($urandom);
      dwell = 16'($urandom_range(0, 7));
      load_valid = 1'b1;
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    int b;
    b = 0;
    while ((q.size() != 0 || dq.size() != 0) && b < 20000) begin
      @(negedge clk);
      b++;
    end
    repeat (3) @(negedge clk);
    chk("expected events still pending", q.size() + dq.size(), 0);
    chk("freq_ctl_data held", freq_ctl_data, last_val);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, stp, st, dw;
    repeat (3) @(negedge clk);
    chk("reset freq_ctl_data", freq_ctl_data, 0);
    chk("reset ftw_valid", ftw_valid, 0);
    chk("reset sweep_busy", sweep_busy, 0);
    chk("reset sweep_done", sweep_done, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("load_ready after reset", load_ready, 1);
    mon_en = 1'b1;

    do_fixed(1234);
    wait_quiet();
    chk("fixed 1234", freq_ctl_data, 52999895);
    do_fixed(4095);
    wait_quiet();
    do_fixed(0);
    wait_quiet();
    chk("fixed 0", freq_ctl_data, 0);

    do_sweep(100, 103, 1, 1, 1'b0, 1000);
    wait_quiet();
    chk("sweep 100..103 final", freq_ctl_data, ftw_of(103));
    do_sweep(4090, 4095, 4, $urandom_range(0, 3), 1'b0, 1000);
    wait_quiet();
    chk("overflow sweep final", freq_ctl_data, ftw_of(4094));
    do_sweep(50, 20, 3, 2, 1'b0, 1000);
    wait_quiet();
    do_sweep(200, 230, 5, 2, 1'b1, 1000);
    wait_quiet();

    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_fixed($urandom_range(0, MAXC));
      end else begin
        s = $urandom_range(0, MAXC);
        if ($urandom_range(0, 4) == 0 && s > 0) stp = s - $urandom_range(1, s);
        else stp = (s + $urandom_range(0, 24) > MAXC) ? MAXC : s + $urandom_range(0, 24);
        st = $urandom_range(1, 6);
        dw = $urandom_range(0, 3);
        do_sweep(s, stp, st, dw, 1'($urandom_range(0, 1)), 1000);
      end
      wait_quiet();
    end

    // step 0 holds start forever; abort it with an asynchronous reset
    do_sweep(300, 400, 0, 2, 1'b0, 5);
    while (cyc < sw_t0 + 15) @(negedge clk);
    chk("step-0 repeats delivered", q.size(), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset freq_ctl_data", freq_ctl_data, 0);
    chk("async reset ftw_valid", ftw_valid, 0);
    chk("async reset sweep_busy", sweep_busy, 0);
    chk("async reset sweep_done", sweep_done, 0);
    q.delete();
    dq.delete();
    sw_t0 = -10;
    sw_done = -5;
    last_val = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("load_ready after mid-sweep reset", load_ready, 1);
    chk("freq_ctl_data after mid-sweep reset", freq_ctl_data, 0);
    do_fixed(777);
    wait_quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
